// File: rtl/pwm_capture.sv
// PWM capture: synchronises pwm_in and measures the high time and rising-to-rising period
// of each complete cycle in clk cycles. A no-edge timeout flags loss of signal.
module pwm_capture #(
    parameter int WIDTH       = 32,
    parameter int TIMEOUT     = 2_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] high_time,
    output logic [WIDTH-1:0] period,
    output logic             valid,
    output logic             active
);

    typedef enum logic [1:0] {IDLE, WAIT_RISE, HIGH, LOW} state_t;

    localparam logic [WIDTH-1:0] TIMEOUT_CNT = WIDTH'(TIMEOUT);

    logic             sync_reg [SYNC_STAGES];
    logic             prev_reg;
    logic             s_lvl;
    logic             rise;
    logic             fall;
    logic             timed_out;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] hi_lat_reg, hi_lat_next;
    logic [WIDTH-1:0] high_time_reg, high_time_next;
    logic [WIDTH-1:0] period_reg, period_next;
    logic             valid_reg, valid_next;
    logic             active_reg, active_next;

    always_ff @(posedge clk) begin
        if (!rst_n) sync_reg[0] <= 1'b0;
        else        sync_reg[0] <= pwm_in;
    end

    generate
        for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (!rst_n) sync_reg[gi] <= 1'b0;
                else        sync_reg[gi] <= sync_reg[gi-1];
            end
        end
    endgenerate

    assign s_lvl     = sync_reg[SYNC_STAGES-1];
    assign rise      = s_lvl & ~prev_reg;
    assign fall      = ~s_lvl & prev_reg;
    assign timed_out = (cnt_reg == TIMEOUT_CNT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_reg      <= 1'b0;
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            hi_lat_reg    <= '0;
            high_time_reg <= '0;
            period_reg    <= '0;
            valid_reg     <= 1'b0;
            active_reg    <= 1'b0;
        end else begin
            prev_reg      <= s_lvl;
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            hi_lat_reg    <= hi_lat_next;
            high_time_reg <= high_time_next;
            period_reg    <= period_next;
            valid_reg     <= valid_next;
            active_reg    <= active_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        hi_lat_next    = hi_lat_reg;
        high_time_next = high_time_reg;
        period_next    = period_reg;
        valid_next     = 1'b0;
        active_next    = active_reg;
        // Saturate rather than wrap so a dead line can never alias a short period.
        cnt_next       = timed_out ? cnt_reg : cnt_reg + 1'b1;

        case (state_reg)
            IDLE: begin
                if (fall) state_next = WAIT_RISE;
            end
            WAIT_RISE: begin
                if (rise) begin
                    cnt_next   = WIDTH'(1);
                    state_next = HIGH;
                end
            end
            HIGH: begin
                if (fall) begin
                    hi_lat_next = cnt_reg;
                    state_next  = LOW;
                end else if (timed_out) begin
                    high_time_next = '0;
                    period_next    = '0;
                    active_next    = 1'b0;
                    state_next     = IDLE;
                end
            end
            LOW: begin
                // An edge arriving exactly at the timeout still counts as a valid period.
                if (rise) begin
                    high_time_next = hi_lat_reg;
                    period_next    = cnt_reg;
                    valid_next     = 1'b1;
                    active_next    = 1'b1;
                    cnt_next       = WIDTH'(1);
                    state_next     = HIGH;
                end else if (timed_out) begin
                    high_time_next = '0;
                    period_next    = '0;
                    active_next    = 1'b0;
                    state_next     = WAIT_RISE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign high_time = high_time_reg;
    assign period    = period_reg;
    assign valid     = valid_reg;
    assign active    = active_reg;

endmodule
